rst_sequencer: RTL and testbench

- Parametrised power-on and soft reset sequencer for the load-balancer top level.
- Replaces the fixed PLL-lock to PHY/system reset wiring with a timed, ordered release:
  - first the PHY reset,
  - then the system (Avalon/CSR) domain,
  - then the dataplane domain.
- Adds global and per-port soft reset of the Ethernet PHYs, with an arbitrary number of ports.
- Lives in the sys_clk domain. Its outputs feed the PHY reset pins and the reset inputs of lb_system.

---
 rtl/rst_seq_pkg.sv | 29 ++
 rtl/port_rst_timer.sv | 49 ++++
 rtl/signal_sync.sv | 23 ++
 rtl/rst_sequencer.sv | 144 ++++++++++++++
 tb/tb_rst_sequencer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
// Shared state encoding and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    localparam int StateW = 3;

    typedef enum logic [StateW-1:0] {
        ST_HOLD     = 3'd0,
        ST_PHY_RST  = 3'd1,
        ST_PHY_WAIT = 3'd2,
        ST_SYS_REL  = 3'd3,
        ST_DP_REL   = 3'd4,
        ST_RUN      = 3'd5
    } state_e;

    // Bits needed to hold a down-counter value of max_cycles-1 (at least one bit).
    function automatic int cnt_width(input int max_cycles);
        if (max_cycles <= 2) begin
            return 1;
        end
        return $clog2(max_cycles);
    endfunction

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/port_rst_timer.sv
// Per-port soft-reset timer: busy for exactly Cycles cycles after start, clear aborts.
module port_rst_timer #(
    parameter int Cycles = 8,
    parameter int CntW   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic clear_i,
    output logic busy_o,
    output logic busy_d_o
);

    logic            busy_q, busy_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CntW'(Cycles - 1);
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o   = busy_q;
    // Exposed so the parent can register phy_rst_n on the same edge as busy.
    assign busy_d_o = busy_d;

endmodule

// File: rtl/signal_sync.sv
// Multi-flop synchroniser for a single asynchronous level; resets to 0.
module signal_sync #(
    parameter int Depth = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [Depth-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Depth-2:0], d_i};
        end
    end

    assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/rst_sequencer.sv
// Ordered PHY -> system -> dataplane reset release with global and per-port PHY soft reset.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NumPorts       = 2,
    parameter int SyncDepth      = 4,
    parameter int PhyRstCycles   = 1000000,
    parameter int PhyWaitCycles  = 250000,
    parameter int StageGapCycles = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                locked_i,
    input  logic                global_rst_req,
    input  logic [NumPorts-1:0] port_rst_req,
    output logic [NumPorts-1:0] phy_rst_n,
    output logic                sys_rst_n,
    output logic                dp_rst_n,
    output logic                ready,
    output logic [NumPorts-1:0] port_busy,
    output logic [StateW-1:0]   state_o
);

    localparam int MaxCycles = max_of3(PhyRstCycles, PhyWaitCycles, StageGapCycles);
    localparam int CntW      = cnt_width(MaxCycles);
    localparam int PortCntW  = cnt_width(PhyRstCycles);

    logic                locked_s;
    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                global_go;
    logic                port_clear;
    logic [NumPorts-1:0] port_start;
    logic [NumPorts-1:0] busy_q, busy_d;

    logic [NumPorts-1:0] phy_rst_n_q, phy_rst_n_d;
    logic                sys_rst_n_q, sys_rst_n_d;
    logic                dp_rst_n_q, dp_rst_n_d;
    logic                ready_q, ready_d;

    signal_sync #(
        .Depth(SyncDepth)
    ) u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (locked_i),
        .q_o  (locked_s)
    );

    // Next state: base sequencing first, then global request, then lock loss overrides all.
    always_comb begin
        state_d   = state_q;
        global_go = 1'b0;
        unique case (state_q)
            ST_HOLD:     if (locked_s)      state_d = ST_PHY_RST;
            ST_PHY_RST:  if (cnt_q == '0)   state_d = ST_PHY_WAIT;
            ST_PHY_WAIT: if (cnt_q == '0)   state_d = ST_SYS_REL;
            ST_SYS_REL:  if (cnt_q == '0)   state_d = ST_DP_REL;
            ST_DP_REL:   if (cnt_q == '0)   state_d = ST_RUN;
            ST_RUN:                         state_d = ST_RUN;
            default:                        state_d = ST_HOLD;
        endcase
        if (global_rst_req &&
            (state_q inside {ST_PHY_WAIT, ST_SYS_REL, ST_DP_REL, ST_RUN})) begin
            state_d   = ST_PHY_RST;
            global_go = 1'b1;
        end
        if (!locked_s) begin
            state_d = ST_HOLD;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            unique case (state_d)
                ST_PHY_RST:  cnt_d = CntW'(PhyRstCycles - 1);
                ST_PHY_WAIT: cnt_d = CntW'(PhyWaitCycles - 1);
                ST_SYS_REL:  cnt_d = CntW'(StageGapCycles - 1);
                ST_DP_REL:   cnt_d = CntW'(StageGapCycles - 1);
                default:     cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_comb begin
        port_clear = !locked_s || global_go;
        port_start = '0;
        if ((state_q == ST_RUN) && !port_clear) begin
            port_start = port_rst_req & ~busy_q;
        end
    end

    for (genvar i = 0; i < NumPorts; i++) begin : g_port
        port_rst_timer #(
            .Cycles(PhyRstCycles),
            .CntW  (PortCntW)
        ) u_timer (
            .clk     (clk),
            .rst_n   (rst_n),
            .start_i (port_start[i]),
            .clear_i (port_clear),
            .busy_o  (busy_q[i]),
            .busy_d_o(busy_d[i])
        );
    end

    // Outputs are decoded from next state so they switch on the same edge as state_q.
    always_comb begin
        phy_rst_n_d = {NumPorts{state_d inside {ST_PHY_WAIT, ST_SYS_REL, ST_DP_REL, ST_RUN}}}
                      & ~busy_d;
        sys_rst_n_d = state_d inside {ST_SYS_REL, ST_DP_REL, ST_RUN};
        dp_rst_n_d  = state_d inside {ST_DP_REL, ST_RUN};
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            phy_rst_n_q <= '0;
            sys_rst_n_q <= 1'b0;
            dp_rst_n_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phy_rst_n_q <= phy_rst_n_d;
            sys_rst_n_q <= sys_rst_n_d;
            dp_rst_n_q  <= dp_rst_n_d;
            ready_q     <= ready_d;
        end
    end

    assign phy_rst_n = phy_rst_n_q;
    assign sys_rst_n = sys_rst_n_q;
    assign dp_rst_n  = dp_rst_n_q;
    assign ready     = ready_q;
    assign port_busy = busy_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: one nominal instance and one minimum-timing instance.
module tb_rst_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Nominal instance: P=8, W=4, G=2
    logic       rst_n_a = 1'b0, locked_a = 1'b0, glob_a = 1'b0;
    logic [1:0] preq_a = 2'b00;
    logic [1:0] phy_a, busy_a;
    logic       sys_a, dp_a, rdy_a;
    logic [2:0] st_a;

    // Boundary instance: every timed state one cycle
    logic       rst_n_b = 1'b0, locked_b = 1'b0, glob_b = 1'b0;
    logic [1:0] preq_b = 2'b00;
    logic [1:0] phy_b, busy_b;
    logic       sys_b, dp_b, rdy_b;
    logic [2:0] st_b;

    int n_checks = 0;
    int n_pass   = 0;

    rst_sequencer #(
        .NumPorts(2), .SyncDepth(2), .PhyRstCycles(8), .PhyWaitCycles(4), .StageGapCycles(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n_a), .locked_i(locked_a), .global_rst_req(glob_a),
        .port_rst_req(preq_a), .phy_rst_n(phy_a), .sys_rst_n(sys_a), .dp_rst_n(dp_a),
        .ready(rdy_a), .port_busy(busy_a), .state_o(st_a)
    );

    rst_sequencer #(
        .NumPorts(2), .SyncDepth(2), .PhyRstCycles(1), .PhyWaitCycles(1), .StageGapCycles(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .locked_i(locked_b), .global_rst_req(glob_b),
        .port_rst_req(preq_b), .phy_rst_n(phy_b), .sys_rst_n(sys_b), .dp_rst_n(dp_b),
        .ready(rdy_b), .port_busy(busy_b), .state_o(st_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected state k edges after the triggering event, PHY_RST entered at edge t0.
    function automatic logic [2:0] exp_state(input int k, input int t0);
        if (k < t0)      return 3'd0;
        if (k < t0 + 8)  return 3'd1;
        if (k < t0 + 12) return 3'd2;
        if (k < t0 + 14) return 3'd3;
        if (k < t0 + 16) return 3'd4;
        return 3'd5;
    endfunction

    task automatic check_all_a(input string tag, input logic [2:0] es, input logic [1:0] ebusy);
        logic [1:0] ephy;
        ephy = (es >= 3'd2) ? ~ebusy : 2'b00;
        check($sformatf("%s.state", tag), st_a, es);
        check($sformatf("%s.phy", tag), phy_a, ephy);
        check($sformatf("%s.sys", tag), sys_a, es >= 3'd3);
        check($sformatf("%s.dp", tag), dp_a, es >= 3'd4);
        check($sformatf("%s.ready", tag), rdy_a, es == 3'd5);
        check($sformatf("%s.busy", tag), busy_a, ebusy);
    endtask

    // Checks every output on every edge of a full release sequence; pulses cleared after edge 1.
    task automatic check_release(input int t0, input string tag);
        for (int k = 1; k <= t0 + 16; k++) begin
            tick();
            glob_a = 1'b0;
            preq_a = 2'b00;
            check_all_a($sformatf("%s@%0d", tag, k), exp_state(k, t0), 2'b00);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_all_a("reset", 3'd0, 2'b00);

        // 1. Power-up
        rst_n_a  = 1'b1;
        locked_a = 1'b1;
        check_release(3, "powerup");

        // 2. Port 0 soft reset with an ignored repeat pulse
        preq_a = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            preq_a = (k == 2) ? 2'b01 : 2'b00;
            check_all_a($sformatf("port0@%0d", k), 3'd5, (k <= 7) ? 2'b01 : 2'b00);
        end

        // 3. Global reset wins over a simultaneous port request
        glob_a = 1'b1;
        preq_a = 2'b10;
        check_release(1, "global");

        // 4a. Lock loss during an active port reset
        preq_a = 2'b01;
        tick();
        preq_a = 2'b00;
        check_all_a("lockport.start", 3'd5, 2'b01);
        tick();
        locked_a = 1'b0;
        tick();
        tick();
        check_all_a("lockport.sync", 3'd5, 2'b01);
        tick();
        check_all_a("lockport.hold", 3'd0, 2'b00);
        tick();
        locked_a = 1'b1;
        check_release(3, "relock1");

        // 4b. Lock loss during SYS_REL
        glob_a = 1'b1;
        tick();
        glob_a = 1'b0;
        repeat (12) tick();
        check_all_a("locksys.sysrel", 3'd3, 2'b00);
        locked_a = 1'b0;
        repeat (3) tick();
        check_all_a("locksys.hold", 3'd0, 2'b00);
        locked_a = 1'b1;
        check_release(3, "relock2");

        // 5. Asynchronous reset mid-PHY_WAIT
        glob_a = 1'b1;
        tick();
        glob_a = 1'b0;
        repeat (9) tick();
        check_all_a("async.phywait", 3'd2, 2'b00);
        #3;
        rst_n_a = 1'b0;
        #1;
        check_all_a("async.assert", 3'd0, 2'b00);
        tick();
        check_all_a("async.held", 3'd0, 2'b00);
        rst_n_a = 1'b1;
        check_release(3, "async.restart");

        // 6. Minimum timing on the boundary instance
        locked_b = 1'b1;
        rst_n_b  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] es;
            tick();
            es = (k < 3) ? 3'd0 : (k >= 7) ? 3'd5 : 3'(k - 2);
            check($sformatf("bnd@%0d.state", k), st_b, es);
            check($sformatf("bnd@%0d.phy", k), phy_b, (es >= 3'd2) ? 2'b11 : 2'b00);
            check($sformatf("bnd@%0d.sys", k), sys_b, es >= 3'd3);
            check($sformatf("bnd@%0d.dp", k), dp_b, es >= 3'd4);
            check($sformatf("bnd@%0d.ready", k), rdy_b, es == 3'd5);
        end
        preq_b = 2'b11;
        tick();
        preq_b = 2'b00;
        check("bnd.pulse.phy", phy_b, 2'b00);
        check("bnd.pulse.busy", busy_b, 2'b11);
        check("bnd.pulse.ready", rdy_b, 1'b1);
        tick();
        check("bnd.after.phy", phy_b, 2'b11);
        check("bnd.after.busy", busy_b, 2'b00);
        check("bnd.after.ready", rdy_b, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
